id_ex_pipeline: RTL and testbench
=================================

ID_EX_PIPELINE -- requirements
Module: id_ex_pipeline

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of register data, PC and immediate.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, width of register indices.
REQ-003 SHALL have port iClk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port iRst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port iValid  input  1  decode stage holds a valid instruction.
REQ-006 SHALL have port iPC  input  DATA_WIDTH  PC of decoded instruction.
REQ-007 SHALL have port iRs1 / iRs2  input  ADDRESS_WIDTH each  source register indices (two ports).
REQ-008 SHALL have port iRd  input  ADDRESS_WIDTH  destination register index.
REQ-009 SHALL have port iImm  input  DATA_WIDTH  sign-extended immediate.
REQ-010 SHALL have port iCtrl  input  ctrl_t (7)  {reg_write, mem_read, mem_write, alu_ctrl[3:0]}.
REQ-011 SHALL have port iRegData1 / iRegData2  input  DATA_WIDTH each  asynchronous register-file read data.
REQ-012 SHALL have port iWbWriteEn  input  1  writeback is writing the register file this cycle.
REQ-013 SHALL have port iWbAddr  input  ADDRESS_WIDTH  writeback destination index.
REQ-014 SHALL have port iWbData  input  DATA_WIDTH  writeback data.
REQ-015 SHALL have port iStall  input  1  downstream stall; hold all state.
REQ-016 SHALL have port iFlush  input  1  taken branch or jump; discard the instruction being captured.
REQ-017 SHALL have ports oValid, oPC, oRs1, oRs2, oRd, oImm, oCtrl  output  widths as inputs  registered EX-stage copies.
REQ-018 SHALL have ports oRs1Data / oRs2Data  output  DATA_WIDTH each  registered operands after writeback bypass.
REQ-019 SHALL have port oLoadUseStall  output  1  combinational; decode and PC hold this cycle.
REQ-020 SHALL have port oBubbleCount  output  16  saturating count of inserted bubbles.

Function
REQ-021 SHALL update registers with priority: iRst > iFlush > iStall > load-use bubble > normal capture.
REQ-022 SHALL on iFlush clear oValid and oCtrl to 0 at next edge, regardless of iStall; other data fields are don't-care.
REQ-023 SHALL on iStall (no flush) hold every register, including oBubbleCount.
REQ-024 SHALL assert oLoadUseStall iff iValid & oValid & oCtrl.mem_read & oRd!=0 & (oRd==iRs1 | oRd==iRs2), and never while iFlush=1.
REQ-025 SHALL on load-use (no flush, no stall) load oValid=0, oCtrl=0 and increment oBubbleCount, saturating at 16'hFFFF.
REQ-026 SHALL otherwise capture all iX into oX with latency one cycle; oValid<=iValid, and oCtrl<=0 when iValid=0.
REQ-027 SHALL bypass per operand: if iWbWriteEn & iWbAddr!=0 & iWbAddr==iRsN, capture iWbData, else iRegDataN.
REQ-028 SHALL capture 0 for an operand whose index is 0, independent of bypass and read data.
REQ-029 SHALL apply bypass to both operands simultaneously when iRs1==iRs2==iWbAddr.

Reset
REQ-030 SHALL on iRst drive oValid=0, oCtrl=0, oPC=0, oRs1=oRs2=oRd=0, oImm=0, oRs1Data=oRs2Data=0, oBubbleCount=0 immediately, without waiting for a clock edge.
REQ-031 SHALL keep oLoadUseStall=0 during reset, since oValid=0; reset mid-stall or mid-bubble discards all state.

Structure
REQ-032 SHALL place ctrl_t, the alu_ctrl encoding and the BUBBLE_CNT_W=16 constant in shared package riscv_pkg.
REQ-033 SHALL put load-use detection in a combinational sub-module hazard_detect; bypass and registers remain in id_ex_pipeline.

Verification
REQ-034 SHALL check bypass: iRs1=5, iRegData1=0x11, iWbWriteEn=1, iWbAddr=5, iWbData=0xABCD -> oRs1Data=0xABCD next cycle; iWbAddr=0 case gives 0x11.
REQ-035 SHALL check load-use: EX holds lw x7 (mem_read=1), decode iRs2=7 -> oLoadUseStall=1, next oValid=0, oCtrl=0, oBubbleCount=1; retried instruction captured the following cycle.
REQ-036 SHALL check priority: iFlush=1 with iStall=1 -> oValid=0 next edge; iStall=1 alone for 3 cycles -> all outputs unchanged.
REQ-037 SHALL check x0: iRs1=0, iRegData1=0xDEAD, iWbAddr=0, iWbWriteEn=1 -> oRs1Data=0; EX load with oRd=0 never asserts oLoadUseStall.
REQ-038 SHALL check async reset: assert iRst mid-cycle after bubbles -> all outputs 0 before next edge; force 65540 bubbles -> oBubbleCount=0xFFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared decode/execute types for the RISC-V core.
// Control bundle layout, ALU op encoding and bubble counter width.
package riscv_pkg;

    localparam int BUBBLE_CNT_W = 16;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9,
        ALU_LUI  = 4'hA
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the EX-stage load and decode.
// Purely combinational; suppressed while a flush is in progress.
module hazard_detect
    import riscv_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     iValid,
    input  logic                     iFlush,
    input  logic [ADDRESS_WIDTH-1:0] iRs1,
    input  logic [ADDRESS_WIDTH-1:0] iRs2,
    input  logic                     iExValid,
    input  ctrl_t                    iExCtrl,
    input  logic [ADDRESS_WIDTH-1:0] iExRd,
    output logic                     oLoadUse
);

    logic rd_match;

    assign rd_match = (iExRd != '0) && ((iExRd == iRs1) || (iExRd == iRs2));

    assign oLoadUse = iValid && iExValid && iExCtrl.mem_read
                    && rd_match && !iFlush;

endmodule

// File: rtl/id_ex_pipeline.sv
// ID/EX pipeline register with writeback bypass and load-use bubbles.
// Priority: reset, flush, stall, bubble, capture.
module id_ex_pipeline
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iValid,
    input  logic [DATA_WIDTH-1:0]    iPC,
    input  logic [ADDRESS_WIDTH-1:0] iRs1,
    input  logic [ADDRESS_WIDTH-1:0] iRs2,
    input  logic [ADDRESS_WIDTH-1:0] iRd,
    input  logic [DATA_WIDTH-1:0]    iImm,
    input  ctrl_t                    iCtrl,
    input  logic [DATA_WIDTH-1:0]    iRegData1,
    input  logic [DATA_WIDTH-1:0]    iRegData2,
    input  logic                     iWbWriteEn,
    input  logic [ADDRESS_WIDTH-1:0] iWbAddr,
    input  logic [DATA_WIDTH-1:0]    iWbData,
    input  logic                     iStall,
    input  logic                     iFlush,
    output logic                     oValid,
    output logic [DATA_WIDTH-1:0]    oPC,
    output logic [ADDRESS_WIDTH-1:0] oRs1,
    output logic [ADDRESS_WIDTH-1:0] oRs2,
    output logic [ADDRESS_WIDTH-1:0] oRd,
    output logic [DATA_WIDTH-1:0]    oImm,
    output ctrl_t                    oCtrl,
    output logic [DATA_WIDTH-1:0]    oRs1Data,
    output logic [DATA_WIDTH-1:0]    oRs2Data,
    output logic                     oLoadUseStall,
    output logic [BUBBLE_CNT_W-1:0]  oBubbleCount
);

    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] rs1_q, rs1_d;
    logic [ADDRESS_WIDTH-1:0] rs2_q, rs2_d;
    logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]    imm_q, imm_d;
    ctrl_t                    ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]    op1_q, op1_d;
    logic [DATA_WIDTH-1:0]    op2_q, op2_d;
    logic [BUBBLE_CNT_W-1:0]  cnt_q, cnt_d;
    logic                     load_use;

    // x0 always reads zero; otherwise the writeback value wins over the RF.
    function automatic logic [DATA_WIDTH-1:0] bypass(
        input logic [ADDRESS_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]    rf,
        input logic                     wb_en,
        input logic [ADDRESS_WIDTH-1:0] wb_addr,
        input logic [DATA_WIDTH-1:0]    wb_data
    );
        if (rs == '0)
            return '0;
        if (wb_en && (wb_addr != '0) && (wb_addr == rs))
            return wb_data;
        return rf;
    endfunction

    hazard_detect #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_hazard (
        .iValid   (iValid),
        .iFlush   (iFlush),
        .iRs1     (iRs1),
        .iRs2     (iRs2),
        .iExValid (valid_q),
        .iExCtrl  (ctrl_q),
        .iExRd    (rd_q),
        .oLoadUse (load_use)
    );

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        if (iFlush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (iStall) begin
            valid_d = valid_q;
        end else if (load_use) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
            if (cnt_q != '1)
                cnt_d = cnt_q + BUBBLE_CNT_W'(1);
        end else begin
            valid_d = iValid;
            pc_d    = iPC;
            rs1_d   = iRs1;
            rs2_d   = iRs2;
            rd_d    = iRd;
            imm_d   = iImm;
            ctrl_d  = iValid ? iCtrl : CTRL_NOP;
            op1_d   = bypass(iRs1, iRegData1, iWbWriteEn, iWbAddr, iWbData);
            op2_d   = bypass(iRs2, iRegData2, iWbWriteEn, iWbAddr, iWbData);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= CTRL_NOP;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oValid        = valid_q;
    assign oPC           = pc_q;
    assign oRs1          = rs1_q;
    assign oRs2          = rs2_q;
    assign oRd           = rd_q;
    assign oImm          = imm_q;
    assign oCtrl         = ctrl_q;
    assign oRs1Data      = op1_q;
    assign oRs2Data      = op2_q;
    assign oLoadUseStall = load_use;
    assign oBubbleCount  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline.sv
// Bench for id_ex_pipeline: directed cases plus random traffic
// checked against an instruction-level reference model.
module tb_id_ex_pipeline;
    import riscv_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          iClk, iRst, iValid;
    logic [DW-1:0] iPC, iImm, iRegData1, iRegData2, iWbData;
    logic [AW-1:0] iRs1, iRs2, iRd, iWbAddr;
    ctrl_t         iCtrl;
    logic          iWbWriteEn, iStall, iFlush;

    logic          oValid, oLoadUseStall;
    logic [DW-1:0] oPC, oImm, oRs1Data, oRs2Data;
    logic [AW-1:0] oRs1, oRs2, oRd;
    ctrl_t         oCtrl;
    logic [15:0]   oBubbleCount;

    id_ex_pipeline #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .iPC(iPC),
        .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd), .iImm(iImm),
        .iCtrl(iCtrl), .iRegData1(iRegData1), .iRegData2(iRegData2),
        .iWbWriteEn(iWbWriteEn), .iWbAddr(iWbAddr), .iWbData(iWbData),
        .iStall(iStall), .iFlush(iFlush),
        .oValid(oValid), .oPC(oPC), .oRs1(oRs1), .oRs2(oRs2),
        .oRd(oRd), .oImm(oImm), .oCtrl(oCtrl),
        .oRs1Data(oRs1Data), .oRs2Data(oRs2Data),
        .oLoadUseStall(oLoadUseStall), .oBubbleCount(oBubbleCount)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;

    // Reference EX-stage contents; m_known clears when data fields
    // become don't-care (after a flush or bubble).
    logic          m_valid;
    logic [6:0]    m_ctrl;
    logic [DW-1:0] m_pc, m_imm, m_d1, m_d2;
    logic [AW-1:0] m_rs1, m_rs2, m_rd;
    int            m_bubbles;
    bit            m_known;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat_cnt(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    function automatic logic [DW-1:0] ref_opnd(input logic [AW-1:0] rs,
                                               input logic [DW-1:0] rf);
        if (rs == 0) return '0;
        if (iWbWriteEn && iWbAddr == rs) return iWbData;
        return rf;
    endfunction

    function automatic bit ref_lu();
        return !iFlush && iValid && m_valid && m_ctrl[5] && m_rd != 0
               && (m_rd == iRs1 || m_rd == iRs2);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctrl = '0; m_pc = '0; m_imm = '0;
        m_d1 = '0; m_d2 = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_bubbles = 0; m_known = 1;
    endtask

    task automatic check_outputs(input string p);
        chk({p, "_valid"}, 32'(oValid), 32'(m_valid));
        chk({p, "_ctrl"}, 32'(oCtrl), 32'(m_ctrl));
        chk({p, "_cnt"}, 32'(oBubbleCount), 32'(sat_cnt(m_bubbles)));
        if (m_known) begin
            chk({p, "_pc"}, oPC, m_pc);
            chk({p, "_imm"}, oImm, m_imm);
            chk({p, "_rs1"}, 32'(oRs1), 32'(m_rs1));
            chk({p, "_rs2"}, 32'(oRs2), 32'(m_rs2));
            chk({p, "_rd"}, 32'(oRd), 32'(m_rd));
            chk({p, "_d1"}, oRs1Data, m_d1);
            chk({p, "_d2"}, oRs2Data, m_d2);
        end
    endtask

    // One clock: check hazard output, advance the model, compare after edge.
    task automatic step(input string p);
        bit lu;
        #1;
        lu = ref_lu();
        chk({p, "_lustall"}, 32'(oLoadUseStall), 32'(lu));
        if (iFlush) begin
            m_valid = 0; m_ctrl = '0; m_known = 0;
        end else if (iStall) begin
            m_known = m_known;
        end else if (lu) begin
            m_valid = 0; m_ctrl = '0; m_known = 0;
            m_bubbles++;
        end else begin
            m_valid = iValid;
            m_ctrl  = iValid ? 7'(iCtrl) : 7'd0;
            m_pc = iPC; m_imm = iImm;
            m_rs1 = iRs1; m_rs2 = iRs2; m_rd = iRd;
            m_d1 = ref_opnd(iRs1, iRegData1);
            m_d2 = ref_opnd(iRs2, iRegData2);
            m_known = 1;
        end
        @(posedge iClk);
        #1;
        check_outputs(p);
    endtask

    task automatic idle();
        iValid = 0; iPC = '0; iImm = '0; iRs1 = '0; iRs2 = '0; iRd = '0;
        iCtrl = CTRL_NOP; iRegData1 = '0; iRegData2 = '0;
        iWbWriteEn = 0; iWbAddr = '0; iWbData = '0;
        iStall = 0; iFlush = 0;
    endtask

    task automatic rand_in();
        iValid = ($urandom_range(0, 3) != 0);
        iFlush = ($urandom_range(0, 15) == 0);
        iStall = ($urandom_range(0, 7) == 0);
        iPC = $urandom; iImm = $urandom;
        iRs1 = 5'($urandom_range(0, 7));
        iRs2 = 5'($urandom_range(0, 7));
        iRd  = 5'($urandom_range(0, 7));
        iCtrl = 7'($urandom);
        if ($urandom_range(0, 1) == 1) iCtrl.mem_read = 1'b1;
        iRegData1 = $urandom; iRegData2 = $urandom;
        iWbWriteEn = 1'($urandom);
        iWbAddr = 5'($urandom_range(0, 7));
        iWbData = $urandom;
    endtask

    // Same load re-presented every cycle: alternates capture and bubble.
    task automatic load_pattern();
        idle();
        iValid = 1; iRd = 5'd7; iRs1 = 5'd7; iPC = 32'h200;
        iCtrl = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0,
                  alu_ctrl: ALU_ADD};
    endtask

    logic [DW-1:0] held_pc;

    initial begin
        idle();
        iRst = 1'b1;
        #2;
        model_reset();
        check_outputs("reset");
        chk("reset_lustall", 32'(oLoadUseStall), 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        step("idle");

        // writeback bypass
        iValid = 1; iRs1 = 5'd5; iRegData1 = 32'h11;
        iWbWriteEn = 1; iWbAddr = 5'd5; iWbData = 32'hABCD;
        step("byp");
        chk("byp_hit", oRs1Data, 32'hABCD);
        iWbAddr = 5'd0;
        step("byp0");
        chk("byp_wbaddr0", oRs1Data, 32'h11);
        iRs2 = 5'd5; iRegData2 = 32'h22; iWbAddr = 5'd5;
        step("byp2");
        chk("byp_both1", oRs1Data, 32'hABCD);
        chk("byp_both2", oRs2Data, 32'hABCD);

        // x0 operand
        idle();
        iValid = 1; iRs1 = 5'd0; iRegData1 = 32'hDEAD;
        iWbWriteEn = 1; iWbAddr = 5'd0; iWbData = 32'hBEEF;
        step("x0");
        chk("x0_opnd", oRs1Data, 32'd0);

        // load-use: lw x7 then consumer of x7
        idle();
        iValid = 1; iRd = 5'd7; iPC = 32'h100;
        iCtrl = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0,
                  alu_ctrl: ALU_ADD};
        step("lw");
        iRs1 = 5'd1; iRs2 = 5'd7; iRd = 5'd8; iPC = 32'h104;
        iCtrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                  alu_ctrl: ALU_SUB};
        #1;
        chk("lu_assert", 32'(oLoadUseStall), 32'd1);
        step("lu");
        chk("lu_valid", 32'(oValid), 32'd0);
        chk("lu_ctrl", 32'(oCtrl), 32'd0);
        chk("lu_cnt", 32'(oBubbleCount), 32'd1);
        step("retry");
        chk("retry_valid", 32'(oValid), 32'd1);
        chk("retry_pc", oPC, 32'h104);

        // load into x0 never stalls
        idle();
        iValid = 1; iRd = 5'd0;
        iCtrl = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0,
                  alu_ctrl: ALU_ADD};
        step("lwx0");
        iCtrl = CTRL_NOP;
        #1;
        chk("x0_load_nostall", 32'(oLoadUseStall), 32'd0);
        step("x0use");

        // flush beats stall
        idle();
        iValid = 1; iPC = 32'h300; iCtrl = 7'h45;
        step("pre_flush");
        iFlush = 1; iStall = 1;
        step("flush");
        chk("flush_stall_valid", 32'(oValid), 32'd0);

        // stall holds for three cycles
        idle();
        iValid = 1; iPC = 32'h400; iRd = 5'd3; iCtrl = 7'h12;
        held_pc = iPC;
        step("pre_stall");
        for (int i = 0; i < 3; i++) begin
            rand_in();
            iFlush = 0; iStall = 1;
            step("stall");
            chk("stall_pc", oPC, held_pc);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            step("rnd");
        end

        // async reset mid-cycle after bubbles
        load_pattern();
        for (int i = 0; i < 6; i++) step("bub");
        #2;
        iRst = 1'b1;
        #1;
        model_reset();
        check_outputs("arst");
        chk("arst_lustall", 32'(oLoadUseStall), 32'd0);
        idle();
        @(negedge iClk);
        iRst = 1'b0;
        step("post_rst");

        // saturation: 20 real bubbles, jump ahead, 20 more
        load_pattern();
        for (int i = 0; i < 40; i++) step("sat_a");
        force dut.cnt_q = 16'hFFF0;
        #1;
        release dut.cnt_q;
        m_bubbles = 65520;
        #1;
        chk("preload_cnt", 32'(oBubbleCount), 32'h0000FFF0);
        for (int i = 0; i < 40; i++) step("sat_b");
        chk("sat_final", 32'(oBubbleCount), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
